wb_spi_slave: RTL and testbench
===============================

# wb_spi_slave

SPI responder (slave) with a Wishbone slave register port: lets the SoC act as the far end of the SPI link that the existing Wishbone SPI master drives. An external master's SCK/CS_n/MOSI are oversampled in the `wb_clk_i` domain, received bytes go into an RX FIFO, and the next byte to return on MISO comes from a TX holding register. Software reaches it over the same 32-bit Wishbone bus as the other peripherals.

## Interface
- `RX_DEPTH`, default 4: RX FIFO depth in bytes; power of two, ≥2.
- `wb_clk_i`  in  1  system clock; all logic runs on its rising edge.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `wb_adr_i`  in  32  byte address; only [3:2] decoded.
- `wb_dat_i`  in  32  write data; only [7:0] used.
- `wb_dat_o`  out  32  read data; [31:8] always 0.
- `wb_we_i`, `wb_stb_i`, `wb_cyc_i`  in  1 each  standard Wishbone classic strobes.
- `wb_sel_i`  in  4  ignored.
- `wb_ack_o`  out  1  single-cycle acknowledge.
- `spi_sclk_i`, `spi_cs_n_i`, `spi_mosi_i`  in  1 each  asynchronous SPI inputs from the master.
- `spi_miso_o`  out  1  serial data to the master.
- `spi_miso_oe_o`  out  1  MISO drive enable; high only while CS_n is low (synchronised) and CTRL.EN=1.
- `spi_irq`  out  1  level interrupt.

## Operation
- Registers (`wb_adr_i[3:2]`):
  - 0 DATA. Read pops the RX FIFO and returns 0 if the FIFO is empty. Write loads TX holding and clears TX_EMPTY.
  - 1 STATUS, read-only except OVR. Bit 0 RX_EMPTY, bit 1 RX_FULL, bit 2 TX_EMPTY, bit 3 OVR (sticky; write 1 to clear), bit 4 BUSY (CS_n low).
  - 2 CTRL. Bit 0 EN, bit 1 RXIE, bit 2 TXIE.
  - 3 reads 0; writes are ignored.
- SPI mode 0 only: MOSI is sampled on SCK rising, MISO changes on SCK falling, MSB first, 8-bit bytes.
- All three SPI inputs pass through 2-flop synchronisers. SCK and CS_n edges are detected from the synchronised value and its previous sample.
- CS_n falling with EN=1:
  - The shift register is loaded from TX holding, or 0x00 if TX_EMPTY.
  - TX_EMPTY is set.
  - The bit counter is cleared.
  - `spi_miso_o` = shift[7].
- Each SCK rising: shift left and insert MOSI; increment the bit counter (3 bits, wraps 7→0).
- 8th rising edge completes the byte:
  - The byte is pushed into the RX FIFO. If the FIFO is full, the byte is dropped and OVR is set.
  - The next SCK falling edge reloads the shift register from TX holding, using the same rule as at CS_n falling, to support back-to-back bytes.
- Other SCK falling edges: `spi_miso_o` = shift[7].
- CS_n rising: the partial byte is discarded, the bit counter is cleared and MISO OE drops. The FIFO is unaffected.
- EN=0: SPI edges are ignored and OE=0. Register access still works.
- `spi_irq` = (RXIE & ~RX_EMPTY) | (TXIE & TX_EMPTY) | OVR.

## Timing
- Reset values:
  - `wb_ack_o`=0, `wb_dat_o`=0, `spi_miso_o`=0, `spi_miso_oe_o`=0, `spi_irq`=0.
  - RX FIFO empty, TX_EMPTY=1, OVR=0, CTRL=0, shift register 0, bit counter 0, synchronisers 1 for CS_n and 0 for SCK/MOSI.
- `wb_ack_o` is registered: it is high the cycle after `cyc&stb` while ack is low, and low for one cycle before the next ack, so no back-to-back acks.
  - Writes and FIFO pops take effect on the ack edge.
  - Read data is valid with ack.
- SPI input pin to detected edge: 3 `wb_clk_i` cycles. MISO update: 1 cycle after the detected falling edge.
- Required: f_sclk ≤ f_wb/8, and CS_n setup/hold to SCK ≥ 4 `wb_clk_i` cycles.
- Simultaneous events:
  - RX push and DATA pop in the same cycle when the FIFO is full: both happen and OVR is not set.
  - DATA write in the same cycle as a TX reload: the reload takes the old holding value, then the new value is stored and TX_EMPTY=0.
  - OVR set and write-1-clear in the same cycle: set wins.
- Reset asserted mid-byte: all state returns to reset values immediately; the partial byte is lost.

## Configuration
- `WB_SPI_SLAVE_IRQ_EN` defined: RXIE/TXIE are implemented and `spi_irq` behaves as above.
- Not defined: `spi_irq` is tied 0, CTRL bits 2:1 read 0 and ignore writes, and the OVR bit still functions.

## Structure
- Shared package `wb_spi_slave_pkg` holds:
  - register offset constants (DATA=0, STATUS=1, CTRL=2);
  - STATUS/CTRL bit index constants;
  - the idle TX fill byte 0x00.
- One sub-module, `spi_slave_rx_fifo`: synchronous FIFO parameterised by `RX_DEPTH`. Ports: push, pop, din, dout, full, empty. Pop on empty is ignored and dout=0.

## Test plan
- Reset, then read STATUS → 0x05 (RX_EMPTY, TX_EMPTY); `spi_irq`=0.
- EN=1, write DATA=0xA5, master sends 0x3C → master receives 0xA5; DATA read returns 0x3C, then STATUS reads 0x05.
- Two back-to-back bytes 0x11, 0x22 in one CS_n frame with TX written once → MISO returns 0xA5 then 0x00; FIFO pops return 0x11, then 0x22.
- With RX_DEPTH=4, send 5 bytes without reading → the 5th is dropped, STATUS=0x0E (RX_FULL, TX_EMPTY, OVR), and pops return bytes 1–4. Write 0x08 to STATUS → OVR clears.
- CS_n deasserted after 5 bits → nothing is pushed. The next full byte 0x81 is received correctly.
- With `WB_SPI_SLAVE_IRQ_EN`, CTRL=0x03, receive one byte → `spi_irq`=1 until the DATA pop, then 0. Without the macro, `spi_irq` stays 0.

Source files
------------

// File: rtl/wb_spi_slave_pkg.sv
// Shared definitions for the Wishbone SPI responder: register map, bit indices, idle fill.
// Optional interrupt logic is controlled by WB_SPI_SLAVE_IRQ_EN.
package wb_spi_slave_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    localparam int unsigned ST_RX_EMPTY = 0;
    localparam int unsigned ST_RX_FULL  = 1;
    localparam int unsigned ST_TX_EMPTY = 2;
    localparam int unsigned ST_OVR      = 3;
    localparam int unsigned ST_BUSY     = 4;

    localparam int unsigned CT_EN   = 0;
    localparam int unsigned CT_RXIE = 1;
    localparam int unsigned CT_TXIE = 2;

    localparam logic [7:0] TX_IDLE_FILL = 8'h00;

    // Byte presented to the master at frame start and at every byte boundary.
    function automatic logic [7:0] tx_next(input logic empty, input logic [7:0] hold);
        return empty ? TX_IDLE_FILL : hold;
    endfunction

endpackage

// File: rtl/spi_slave_rx_fifo.sv
// Synchronous byte FIFO for received SPI data; pop on empty is ignored and dout reads 0.
// A push while full is accepted only when a pop happens in the same cycle.
module spi_slave_rx_fifo #(
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(RX_DEPTH);

    logic [7:0]    mem_q [RX_DEPTH];
    logic [7:0]    mem_d [RX_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_L);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_spi_slave.sv
// SPI mode-0 responder with a 32-bit Wishbone register port and RX FIFO.
// Define WB_SPI_SLAVE_IRQ_EN to implement RXIE/TXIE and the spi_irq output.
module wb_spi_slave
    import wb_spi_slave_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic        spi_sclk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe_o,
    output logic        spi_irq
);

    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i};

    logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
    logic cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_prev_q, cs_prev_d;
    logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        active_q, active_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        byte_done_q, byte_done_d;
    logic        miso_q, miso_d;
    logic [7:0]  tx_hold_q, tx_hold_d;
    logic        tx_empty_q, tx_empty_d;
    logic        ovr_q, ovr_d;
    logic        en_q, en_d;
`ifdef WB_SPI_SLAVE_IRQ_EN
    logic        rxie_q, rxie_d, txie_q, txie_d;
    logic        irq_q, irq_d;
`endif

    logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic        wb_acc, wb_wr, wb_rd;
    reg_addr_e   reg_sel;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_din, rx_dout, reload;
    logic        ovr_clr;
    logic [31:0] status_w, ctrl_w;

    assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
    assign cs_fall   = ~cs_s2_q & cs_prev_q;
    assign cs_rise   = cs_s2_q & ~cs_prev_q;

    assign wb_acc  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wb_wr   = wb_acc & wb_we_i;
    assign wb_rd   = wb_acc & ~wb_we_i;
    assign reg_sel = reg_addr_e'(wb_adr_i[3:2]);
    assign rx_pop  = wb_rd & (reg_sel == REG_DATA);
    assign rx_din  = {shift_q[6:0], mosi_s2_q};
    assign reload  = tx_next(tx_empty_q, tx_hold_q);

    spi_slave_rx_fifo #(
        .RX_DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_din),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        status_w              = '0;
        status_w[ST_RX_EMPTY] = rx_empty;
        status_w[ST_RX_FULL]  = rx_full;
        status_w[ST_TX_EMPTY] = tx_empty_q;
        status_w[ST_OVR]      = ovr_q;
        status_w[ST_BUSY]     = ~cs_s2_q;
        ctrl_w                = '0;
        ctrl_w[CT_EN]         = en_q;
`ifdef WB_SPI_SLAVE_IRQ_EN
        ctrl_w[CT_RXIE]       = rxie_q;
        ctrl_w[CT_TXIE]       = txie_q;
`endif
    end

    always_comb begin
        sclk_s1_d   = spi_sclk_i;
        sclk_s2_d   = sclk_s1_q;
        sclk_prev_d = sclk_s2_q;
        cs_s1_d     = spi_cs_n_i;
        cs_s2_d     = cs_s1_q;
        cs_prev_d   = cs_s2_q;
        mosi_s1_d   = spi_mosi_i;
        mosi_s2_d   = mosi_s1_q;

        ack_d       = wb_acc;
        dat_d       = '0;
        active_d    = active_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        byte_done_d = byte_done_q;
        miso_d      = miso_q;
        tx_hold_d   = tx_hold_q;
        tx_empty_d  = tx_empty_q;
        en_d        = en_q;
        rx_push     = 1'b0;
        ovr_clr     = 1'b0;
`ifdef WB_SPI_SLAVE_IRQ_EN
        rxie_d      = rxie_q;
        txie_d      = txie_q;
`endif

        if (!en_q) begin
            active_d    = 1'b0;
            byte_done_d = 1'b0;
        end else if (cs_fall) begin
            active_d    = 1'b1;
            shift_d     = reload;
            tx_empty_d  = 1'b1;
            bitcnt_d    = '0;
            byte_done_d = 1'b0;
            miso_d      = reload[7];
        end else if (cs_rise) begin
            active_d    = 1'b0;
            bitcnt_d    = '0;
            byte_done_d = 1'b0;
        end else if (active_q) begin
            if (sclk_rise) begin
                shift_d  = rx_din;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    rx_push     = 1'b1;
                    byte_done_d = 1'b1;
                end
            end else if (sclk_fall) begin
                if (byte_done_q) begin
                    shift_d     = reload;
                    tx_empty_d  = 1'b1;
                    byte_done_d = 1'b0;
                    miso_d      = reload[7];
                end else begin
                    miso_d = shift_q[7];
                end
            end
        end

        // Register writes follow the SPI update so a DATA write lands after a same-cycle reload.
        if (wb_wr) begin
            case (reg_sel)
                REG_DATA: begin
                    tx_hold_d  = wb_dat_i[7:0];
                    tx_empty_d = 1'b0;
                end
                REG_STATUS: ovr_clr = wb_dat_i[ST_OVR];
                REG_CTRL: begin
                    en_d = wb_dat_i[CT_EN];
`ifdef WB_SPI_SLAVE_IRQ_EN
                    rxie_d = wb_dat_i[CT_RXIE];
                    txie_d = wb_dat_i[CT_TXIE];
`endif
                end
                default: ;
            endcase
        end

        if (wb_rd) begin
            case (reg_sel)
                REG_DATA:   dat_d = {24'h0, rx_dout};
                REG_STATUS: dat_d = status_w;
                REG_CTRL:   dat_d = ctrl_w;
                default:    dat_d = '0;
            endcase
        end

        ovr_d = (ovr_q & ~ovr_clr) | (rx_push & rx_full & ~rx_pop);

`ifdef WB_SPI_SLAVE_IRQ_EN
        irq_d = (rxie_q & ~rx_empty) | (txie_q & tx_empty_q) | ovr_q;
`endif
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            active_q    <= 1'b0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            byte_done_q <= 1'b0;
            miso_q      <= 1'b0;
            tx_hold_q   <= '0;
            tx_empty_q  <= 1'b1;
            ovr_q       <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            sclk_prev_q <= sclk_prev_d;
            cs_s1_q     <= cs_s1_d;
            cs_s2_q     <= cs_s2_d;
            cs_prev_q   <= cs_prev_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            active_q    <= active_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            byte_done_q <= byte_done_d;
            miso_q      <= miso_d;
            tx_hold_q   <= tx_hold_d;
            tx_empty_q  <= tx_empty_d;
            ovr_q       <= ovr_d;
            en_q        <= en_d;
        end
    end

`ifdef WB_SPI_SLAVE_IRQ_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rxie_q <= 1'b0;
            txie_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            rxie_q <= rxie_d;
            txie_q <= txie_d;
            irq_q  <= irq_d;
        end
    end
    assign spi_irq = irq_q;
`else
    assign spi_irq = 1'b0;
`endif

    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = dat_q;
    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = active_q;

endmodule

// File: tb/tb_wb_spi_slave.sv
// Scoreboard bench for wb_spi_slave: a queue-based reference model predicts register reads
// and MISO bytes; independent monitors compare them as the DUT presents data.
module tb_wb_spi_slave;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_ack_o;
    logic        spi_sclk_i = 1'b0;
    logic        spi_cs_n_i = 1'b1;
    logic        spi_mosi_i = 1'b0;
    logic        spi_miso_o;
    logic        spi_miso_oe_o;
    logic        spi_irq;

    always #5 clk = ~clk;

    wb_spi_slave #(.RX_DEPTH(DEPTH)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_dat_o      (wb_dat_o),
        .wb_we_i       (wb_we_i),
        .wb_stb_i      (wb_stb_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_sel_i      (wb_sel_i),
        .wb_ack_o      (wb_ack_o),
        .spi_sclk_i    (spi_sclk_i),
        .spi_cs_n_i    (spi_cs_n_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .spi_irq       (spi_irq)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  miso_exp_q[$];

    // Reference model state
    logic [7:0] m_rx[$];
    logic [7:0] m_hold = 8'h00;
    bit         m_tx_empty = 1'b1;
    bit         m_ovr = 1'b0;
    bit         m_en = 1'b0;
    bit         m_rxie = 1'b0;
    bit         m_txie = 1'b0;

    logic [7:0] tx_bytes [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic exp_irq();
`ifdef WB_SPI_SLAVE_IRQ_EN
        return (m_rxie && m_rx.size() != 0) || (m_txie && m_tx_empty) || m_ovr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wb_cycle(input logic [1:0] r, input logic we, input logic [31:0] d);
        bit got = 1'b0;
        @(negedge clk);
        wb_adr_i = {28'h0, r, 2'b00};
        wb_dat_i = d;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_ack_timeout: got no ack expected ack within 20 cycles");
        end
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [1:0] r, input string nm);
        logic [31:0] e;
        case (r)
            2'd0: e = (m_rx.size() != 0) ? {24'h0, m_rx.pop_front()} : 32'h0;
            2'd1: e = {27'h0, 1'b0, m_ovr, m_tx_empty, m_rx.size() == DEPTH, m_rx.size() == 0};
`ifdef WB_SPI_SLAVE_IRQ_EN
            2'd2: e = {29'h0, m_txie, m_rxie, m_en};
`else
            2'd2: e = {31'h0, m_en};
`endif
            default: e = 32'h0;
        endcase
        exp_q.push_back(e);
        name_q.push_back(nm);
        wb_cycle(r, 1'b0, 32'h0);
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] d);
        case (r)
            2'd0: begin
                m_hold     = d[7:0];
                m_tx_empty = 1'b0;
            end
            2'd1: if (d[3]) m_ovr = 1'b0;
            2'd2: begin
                m_en   = d[0];
                m_rxie = d[1];
                m_txie = d[2];
            end
            default: ;
        endcase
        wb_cycle(r, 1'b1, d);
    endtask

    // Master drives nbits of tx_bytes MSB first; model predicts what the responder does.
    task automatic spi_frame(input int unsigned nbits);
        int unsigned nfull = nbits / 8;
        if (m_en) begin
            for (int unsigned k = 0; k < nfull; k++) begin
                miso_exp_q.push_back(m_tx_empty ? 8'h00 : m_hold);
                m_tx_empty = 1'b1;
                if (m_rx.size() < DEPTH) m_rx.push_back(tx_bytes[k]);
                else m_ovr = 1'b1;
            end
            m_tx_empty = 1'b1;
        end
        @(negedge clk);
        spi_cs_n_i = 1'b0;
        repeat (8) @(negedge clk);
        check("oe_in_frame", {31'h0, spi_miso_oe_o}, {31'h0, m_en});
        for (int unsigned i = 0; i < nbits; i++) begin
            spi_mosi_i = tx_bytes[i / 8][7 - (i % 8)];
            repeat (8) @(negedge clk);
            spi_sclk_i = 1'b1;
            repeat (8) @(negedge clk);
            spi_sclk_i = 1'b0;
        end
        repeat (8) @(negedge clk);
        spi_cs_n_i = 1'b1;
        repeat (10) @(negedge clk);
        check("oe_after_frame", {31'h0, spi_miso_oe_o}, 32'h0);
    endtask

    // Wishbone read monitor
    bit rd_req = 1'b0;
    always @(posedge clk) rd_req <= wb_cyc_i & wb_stb_i & ~wb_we_i & ~wb_ack_o;

    always @(negedge clk) begin
        if (wb_ack_o && rd_req) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got 0x%08h expected no read ack", wb_dat_o);
            end else begin
                check(name_q.pop_front(), wb_dat_o, exp_q.pop_front());
            end
        end
    end

    // MISO monitor: master-side capture on SCK rising while MISO is driven
    int unsigned mnb = 0;
    logic [7:0]  msh = 8'h00;
    always @(posedge spi_sclk_i or posedge spi_cs_n_i) begin
        if (spi_cs_n_i) begin
            mnb = 0;
        end else if (spi_miso_oe_o) begin
            msh = {msh[6:0], spi_miso_o};
            mnb++;
            if (mnb == 8) begin
                mnb = 0;
                if (miso_exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_miso: got 0x%02h expected no byte", msh);
                end else begin
                    check("miso_byte", {24'h0, msh}, {24'h0, miso_exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_miso", {31'h0, spi_miso_o}, 32'h0);
        check("rst_oe", {31'h0, spi_miso_oe_o}, 32'h0);
        check("rst_irq", {31'h0, spi_irq}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        wb_read(2'd1, "status_reset");
        wb_read(2'd3, "reserved_read");
        wb_write(2'd3, 32'hFF);
        wb_read(2'd1, "status_after_rsvd_write");

        wb_write(2'd2, 32'h1);
        wb_read(2'd2, "ctrl_en");

        wb_write(2'd0, 32'hA5);
        tx_bytes[0] = 8'h3C;
        spi_frame(8);
        wb_read(2'd0, "rx_3c");
        wb_read(2'd1, "status_after_pop");

        wb_write(2'd0, 32'hA5);
        tx_bytes[0] = 8'h11;
        tx_bytes[1] = 8'h22;
        spi_frame(16);
        wb_read(2'd0, "rx_11");
        wb_read(2'd0, "rx_22");

        for (int unsigned k = 0; k < 5; k++) tx_bytes[k] = 8'($urandom);
        spi_frame(40);
        wb_read(2'd1, "status_overrun");
        for (int unsigned k = 0; k < 4; k++) wb_read(2'd0, "rx_overrun_pop");
        wb_read(2'd0, "rx_empty_pop");
        wb_write(2'd1, 32'h08);
        wb_read(2'd1, "status_ovr_cleared");

        wb_write(2'd0, 32'({$urandom} & 32'hFF));
        tx_bytes[0] = 8'hFF;
        spi_frame(5);
        wb_read(2'd1, "status_after_partial");
        tx_bytes[0] = 8'h81;
        spi_frame(8);
        wb_read(2'd0, "rx_81");
        wb_read(2'd0, "rx_empty_after_81");

        wb_write(2'd2, 32'h0);
        wb_write(2'd0, 32'h5A);
        tx_bytes[0] = 8'h77;
        spi_frame(8);
        wb_read(2'd1, "status_disabled");
        wb_write(2'd2, 32'h1);

        for (int unsigned it = 0; it < 8; it++) begin
            int unsigned nb;
            int unsigned extra;
            if ($urandom_range(0, 1) == 1) wb_write(2'd0, 32'({$urandom} & 32'hFF));
            nb    = $urandom_range(1, 5);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int unsigned k = 0; k < 6; k++) tx_bytes[k] = 8'($urandom);
            spi_frame(nb * 8 + extra);
            wb_read(2'd1, "status_rand");
            while (m_rx.size() != 0) wb_read(2'd0, "rx_rand");
            wb_read(2'd0, "rx_rand_empty");
            if (m_ovr) wb_write(2'd1, 32'h08);
        end

        wb_write(2'd2, 32'h3);
        repeat (3) @(negedge clk);
        check("irq_idle", {31'h0, spi_irq}, {31'h0, exp_irq()});
        tx_bytes[0] = 8'($urandom);
        spi_frame(8);
        repeat (3) @(negedge clk);
        check("irq_rx", {31'h0, spi_irq}, {31'h0, exp_irq()});
        wb_read(2'd0, "rx_irq_byte");
        repeat (3) @(negedge clk);
        check("irq_after_pop", {31'h0, spi_irq}, {31'h0, exp_irq()});
        wb_read(2'd2, "ctrl_irq_bits");

        repeat (20) @(negedge clk);
        check("leftover_reads", exp_q.size(), 32'h0);
        check("leftover_miso", miso_exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no finish expected finish before 5ms");
        $fatal(1);
    end

endmodule
